// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if
// Request/grant bundle for the four-requester round-robin arbiter.
//   R1..R4 : level-sensitive request lines (request sources -> arbiter)
//   G1..G4 : registered one-hot grant lines (arbiter -> request sources)
//   ZN     : combinational NOR of R1..R4, 1 when nobody is requesting
//   TO     : one-cycle timeout-release pulse (0 when timeout is compiled out)
// Modports:
//   master : the request side (drives R, observes G/ZN/TO)
//   slave  : the arbiter (observes R, drives G/ZN/TO)
// ---------------------------------------------------------------------------
interface gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if;
  logic R1, R2, R3, R4;
  logic G1, G2, G3, G4;
  logic ZN;
  logic TO;

  modport master (
    output R1, R2, R3, R4,
    input  G1, G2, G3, G4, ZN, TO
  );

  modport slave (
    input  R1, R2, R3, R4,
    output G1, G2, G3, G4, ZN, TO
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__rrarb4_1
// Four-requester round-robin arbiter with registered, one-hot,
// break-before-make grants and a combinational NOR4 idle term.
//
// Ports:
//   CLK : clock, all state updates on the rising edge
//   RST : asynchronous active-high reset
//   bus : slave side of gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if
//         (R1..R4 in, G1..G4 / ZN / TO out)
// Parameter:
//   TMO : maximum consecutive grant cycles per owner (1..255), only
//         meaningful with the timeout feature compiled in.
// Optional feature:
//   GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN enables the grant-length
//   counter and the TO release pulse. Without it a grant is held for as
//   long as its owner keeps requesting and TO is tied low.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(
  parameter int unsigned TMO = 15
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if.slave     bus
);

  if (TMO < 1 || TMO > 255) begin : g_bad_tmo
    $error("TMO must be in the range 1..255");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] own_q, own_d;
  logic [3:0] gnt_q, gnt_d;

`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  logic [3:0] req;
  logic [1:0] cand;
  logic [1:0] pick;
  logic       pick_vld;

  assign req    = {bus.R4, bus.R3, bus.R2, bus.R1};
  assign bus.ZN = ~|req;

  assign bus.G1 = gnt_q[0];
  assign bus.G2 = gnt_q[1];
  assign bus.G3 = gnt_q[2];
  assign bus.G4 = gnt_q[3];

`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
  assign bus.TO = to_q;
`else
  assign bus.TO = 1'b0;
`endif

  // Scan from the farthest offset down to PTR itself so that the asserted
  // request closest to PTR (in rotation order) is the one left in pick.
  always_comb begin
    cand     = ptr_q;
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    gnt_d   = gnt_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick_vld) begin
          own_d   = pick;
          gnt_d   = 4'b0001 << pick;
          state_d = GRANT;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        // A normal release wins over a timeout on the same edge, so TO
        // only fires while the owner is still requesting.
        if (!req[own_q]) begin
          gnt_d   = 4'b0000;
          ptr_d   = own_q + 2'd1;
          state_d = IDLE;
        end
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          gnt_d   = 4'b0000;
          ptr_d   = own_q + 2'd1;
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      own_q   <= 2'd0;
      gnt_q   <= 4'b0000;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4_1;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  logic [3:0] g;

  gf180mcu_fd_sc_mcu7t5v0__rrarb4_1_if bus ();

  gf180mcu_fd_sc_mcu7t5v0__rrarb4_1 #(.TMO(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign g = {bus.G4, bus.G3, bus.G2, bus.G1};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic set_req(input logic [3:0] r);
    bus.R1 = r[0];
    bus.R2 = r[1];
    bus.R3 = r[2];
    bus.R4 = r[3];
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_req(4'b0000);
    #2;
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL reset_g: got %b expected 0000", g); end
    checks++;
    if (bus.TO !== 1'b0) begin errors++; $display("FAIL reset_to: got %b expected 0", bus.TO); end
    checks++;
    if (bus.ZN !== 1'b1) begin errors++; $display("FAIL reset_zn_idle: got %b expected 1", bus.ZN); end
    set_req(4'b0010);
    #1;
    checks++;
    if (bus.ZN !== 1'b0) begin errors++; $display("FAIL reset_zn_req: got %b expected 0", bus.ZN); end
    tick();
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL reset_hold_g: got %b expected 0000", g); end
    set_req(4'b0000);
    RST = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] r;
    logic [3:0] exp;
    int e;
    r = 4'b1111;
    set_req(r);
    tick();
    for (int idx = 0; idx < 5; idx++) begin
      e   = idx % 4;
      exp = 4'b0001 << e;
      checks++;
      if (g !== exp) begin errors++; $display("FAIL rot_grant%0d: got %b expected %b", idx, g, exp); end
      tick();
      checks++;
      if (g !== exp) begin errors++; $display("FAIL rot_hold1_%0d: got %b expected %b", idx, g, exp); end
      tick();
      checks++;
      if (g !== exp) begin errors++; $display("FAIL rot_hold2_%0d: got %b expected %b", idx, g, exp); end
      r[e] = 1'b0;
      set_req(r);
      tick();
      checks++;
      if (g !== 4'b0000) begin errors++; $display("FAIL rot_gap%0d: got %b expected 0000", idx, g); end
      r[e] = 1'b1;
      set_req(r);
      tick();
    end
    // G2 is now held; release it and settle in IDLE with PTR=2.
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL rot_after: got %b expected 0010", g); end
    set_req(4'b0000);
    tick();
    tick();
  endtask

  task automatic test_single_r3();
    set_req(4'b0100);
    #1;
    checks++;
    if (bus.ZN !== 1'b0) begin errors++; $display("FAIL r3_zn: got %b expected 0", bus.ZN); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (g !== 4'b0100) begin errors++; $display("FAIL r3_grant_c%0d: got %b expected 0100", c, g); end
      if (c == 2) begin
        // Drop and re-raise between edges: the owner keeps its grant.
        #1 set_req(4'b0000);
        #2 set_req(4'b0100);
      end
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL r3_release: got %b expected 0000", g); end
    set_req(4'b1111);
    tick();
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL r3_next_g4: got %b expected 1000", g); end
    set_req(4'b0000);
    tick();
    tick();
  endtask

  task automatic test_zn_and_latency();
    checks++;
    if (bus.ZN !== 1'b1 || g !== 4'b0000) begin
      errors++; $display("FAIL zn_idle: got zn=%b g=%b expected zn=1 g=0000", bus.ZN, g);
    end
    // A request pulse that is gone before the edge is never granted.
    set_req(4'b0100);
    #2 set_req(4'b0000);
    tick();
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL pulse_no_grant: got %b expected 0000", g); end
    set_req(4'b0010);
    #1;
    checks++;
    if (bus.ZN !== 1'b0) begin errors++; $display("FAIL zn_same_cycle: got %b expected 0", bus.ZN); end
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL g2_not_yet: got %b expected 0000", g); end
    tick();
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL g2_latency: got %b expected 0010", g); end
    set_req(4'b0000);
    tick();
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL g2_release: got %b expected 0000", g); end
    tick();
  endtask

  task automatic test_async_reset();
    set_req(4'b1000);
    tick();
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL ar_g4: got %b expected 1000", g); end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL ar_clear: got %b expected 0000", g); end
    checks++;
    if (bus.TO !== 1'b0) begin errors++; $display("FAIL ar_to: got %b expected 0", bus.TO); end
    set_req(4'b1111);
    tick();
    RST = 1'b0;
    tick();
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL ar_first_g1: got %b expected 0001", g); end
    set_req(4'b0000);
    tick();
    tick();
  endtask

`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
  task automatic test_timeout();
    RST = 1'b1;
    #2 RST = 1'b0;
    set_req(4'b0011);
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (g !== 4'b0001 || bus.TO !== 1'b0) begin
        errors++; $display("FAIL to_hold_c%0d: got g=%b to=%b expected g=0001 to=0", c, g, bus.TO);
      end
    end
    tick();
    checks++;
    if (g !== 4'b0000 || bus.TO !== 1'b1) begin
      errors++; $display("FAIL to_pulse: got g=%b to=%b expected g=0000 to=1", g, bus.TO);
    end
    tick();
    checks++;
    if (g !== 4'b0010 || bus.TO !== 1'b0) begin
      errors++; $display("FAIL to_next_g2: got g=%b to=%b expected g=0010 to=0", g, bus.TO);
    end
    tick();
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL to_g2_hold: got %b expected 0010", g); end
    set_req(4'b0001);
    tick();
    checks++;
    if (g !== 4'b0000 || bus.TO !== 1'b0) begin
      errors++; $display("FAIL to_g2_release: got g=%b to=%b expected g=0000 to=0", g, bus.TO);
    end
    tick();
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL to_g1_return: got %b expected 0001", g); end
    set_req(4'b0000);
    tick();
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    RST = 1'b1;
    #2 RST = 1'b0;
    set_req(4'b0011);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++;
      if (g !== 4'b0001 || bus.TO !== 1'b0) begin
        errors++;
        if (bad < 5) $display("FAIL nto_hold_c%0d: got g=%b to=%b expected g=0001 to=0", c, g, bus.TO);
        bad++;
      end
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (g !== 4'b0000) begin errors++; $display("FAIL nto_release: got %b expected 0000", g); end
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    set_req(4'b0000);
    test_reset();
    test_rotation();
    test_single_r3();
    test_zn_and_latency();
    test_async_reset();
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
